// File: rtl/mac_feeder_pkg.sv
// Shared constants for the MAC operand feeder:
// register offsets, CTRL/STATUS bit positions and FSM states.
package mac_feeder_pkg;

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_CTRL   = 2'd1;
  localparam logic [1:0] ADR_STATUS = 2'd2;
  localparam logic [1:0] ADR_LEN    = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_OVCLR = 2;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_REM_LSB = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mac_op_fifo.sv
// Synchronous operand FIFO. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module mac_op_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are meaningless while empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !rst_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Wishbone-fed operand FIFO that streams LEN-beat bursts
// of {weights, activation} pairs to a MAC stage.
module mac_operand_feeder
  import mac_feeder_pkg::*;
#(
  parameter int BITS  = 16,
  parameter int DEPTH = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_dat_i,
  input  logic [31:0]     wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  output logic            op_valid_o,
  input  logic            op_ready_i,
  output logic [BITS-1:0] op_a_o,
  output logic [15:0]     op_b_o,
  output logic            op_last_o,
  output logic            irq_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = BITS + 16;

  state_e        state_q;
  logic [7:0]    rem_q;
  logic [7:0]    len_q;
  logic          ovf_q;
  logic          ack_q;
  logic [31:0]   dat_q;

  logic          wb_req;
  logic [1:0]    adr;
  logic          data_wr;
  logic          ctrl_wr;
  logic          start;
  logic          flush;
  logic          ovclr;
  logic          pop;
  logic          busy;
  logic          full;
  logic          empty;
  logic [CW-1:0] cnt;
  logic [FW-1:0] head;
  logic [31:0]   status;
  logic [31:0]   rdata;
  logic          unused_ok;

  assign adr     = wbs_adr_i[3:2];
  assign wb_req  = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign data_wr = wb_req & wbs_we_i & (adr == ADR_DATA)
                 & (wbs_sel_i == 4'hF);
  assign ctrl_wr = wb_req & wbs_we_i & (adr == ADR_CTRL);
  assign start   = ctrl_wr & wbs_dat_i[CTRL_START];
  assign flush   = ctrl_wr & wbs_dat_i[CTRL_FLUSH];
  assign ovclr   = ctrl_wr & wbs_dat_i[CTRL_OVCLR];

  assign busy       = (state_q == S_RUN);
  assign op_valid_o = busy & ~empty;
  assign pop        = op_valid_o & op_ready_i;
  assign op_a_o     = head[BITS-1:0];
  assign op_b_o     = head[FW-1:BITS];
  assign op_last_o  = op_valid_o & (rem_q == 8'd1);
  assign irq_o      = (state_q == S_DONE);
  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;

  assign unused_ok = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i};

  mac_op_fifo #(
    .W     (FW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (data_wr & ~flush),
    .data_i  ({wbs_dat_i[31:16], wbs_dat_i[BITS-1:0]}),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cnt)
  );

  // STATUS word and read-data mux.
  always_comb begin
    status                   = '0;
    status[ST_EMPTY]         = empty;
    status[ST_FULL]          = full;
    status[ST_BUSY]          = busy;
    status[ST_OVF]           = ovf_q;
    status[ST_CNT_LSB +: 8]  = 8'(cnt);
    status[ST_REM_LSB +: 8]  = rem_q;
    rdata                    = '0;
    case (adr)
      ADR_STATUS: rdata = status;
      ADR_LEN:    rdata = {24'b0, len_q};
      default:    rdata = '0;
    endcase
  end

  // Bus side: one-cycle ack, read data, LEN and overflow flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ack_q <= wb_req;
      if (wb_req) dat_q <= wbs_we_i ? 32'h0 : rdata;
      if (wb_req && wbs_we_i && adr == ADR_LEN)
        len_q <= wbs_dat_i[7:0];
      if (ovclr)
        ovf_q <= 1'b0;
      else if (data_wr && full && !pop && !flush)
        ovf_q <= 1'b1;
    end
  end

  // Burst FSM; flush abandons a burst without an interrupt.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && len_q != 8'd0) begin
            state_q <= S_RUN;
            rem_q   <= len_q;
          end
        end
        S_RUN: begin
          if (pop) begin
            rem_q <= rem_q - 8'd1;
            if (rem_q == 8'd1) state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mac_operand_feeder.md
MAC_OPERAND_FEEDER -- requirements
Module: mac_operand_feeder

Interface
REQ-001 SHALL have parameter BITS, 16, operand-A width and op_a_o width.
REQ-002 SHALL have parameter DEPTH, 8, operand FIFO entries; must be a power of 2, minimum 2.
REQ-003 SHALL have port wb_clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset; synchronous and active-high.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone slave cycle, strobe and write-enable.
REQ-006 SHALL have ports wbs_sel_i in 4, wbs_dat_i in 32 and wbs_adr_i in 32; only wbs_adr_i[3:2] is decoded.
REQ-007 SHALL have ports wbs_ack_o out 1 and wbs_dat_o out 32, both registered.
REQ-008 SHALL have port op_valid_o  out  1  operand beat valid to the downstream MAC stage.
REQ-009 SHALL have port op_ready_i  in  1  downstream accepts the beat.
REQ-010 SHALL have ports op_a_o out BITS (operand A) and op_b_o out 16 (two packed 8-bit weights: [7:0] lane 0, [15:8] lane 1).
REQ-011 SHALL have port op_last_o  out  1  marks the final beat of a burst.
REQ-012 SHALL have port irq_o  out  1  one-cycle pulse when a burst completes.

Function
REQ-013 SHALL register-map on adr[3:2]: 0 DATA (write-only push), 1 CTRL (write), 2 STATUS (read), 3 LEN (read/write, [7:0]).
REQ-014 SHALL assert wbs_ack_o for exactly one cycle, in the cycle after cyc&stb is seen with ack low; back-to-back requests therefore ack every other cycle.
REQ-015 SHALL push {dat[31:16] -> op_b, dat[BITS-1:0] -> op_a} into the FIFO on an acked DATA write when wbs_sel_i is 4'hF; a partial sel SHALL be acked and ignored.
REQ-016 SHALL drop a DATA push while the FIFO is full with no pop in that cycle, and SHALL set the sticky overflow bit; the push SHALL be accepted when a pop occurs in the same cycle.
REQ-017 SHALL decode CTRL bit0 as start, bit1 as flush and bit2 as overflow-clear; all three are self-clearing pulses.
REQ-018 SHALL return STATUS as [0] empty, [1] full, [2] busy (state RUN), [3] overflow, [11:4] FIFO count and [23:16] remaining beats; all other bits read 0, and a read of DATA returns 0.
REQ-019 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-020 SHALL move from IDLE to RUN on start when LEN != 0, loading the remaining counter with LEN; start with LEN = 0 SHALL be ignored, and start outside IDLE SHALL be ignored.
REQ-021 SHALL, in RUN, drive op_valid_o = !empty with op_a_o/op_b_o taken from the FIFO head; a beat transfers when op_valid_o & op_ready_i, popping the FIFO and decrementing the remaining counter.
REQ-022 SHALL hold op_a_o/op_b_o/op_last_o stable while op_valid_o is high and op_ready_i is low.
REQ-023 SHALL drive op_last_o = op_valid_o & (remaining == 1).
REQ-024 SHALL, on the last transfer, enter DONE; DONE SHALL pulse irq_o for one cycle and return to IDLE on the next cycle.
REQ-025 SHALL hold op_valid_o low in IDLE and DONE; FIFO entries beyond LEN SHALL remain for the next burst.
REQ-026 SHALL, on flush in any state, empty the FIFO, zero the remaining counter and go to IDLE with no irq; flush SHALL win over a same-cycle push or pop.
REQ-027 SHALL wrap the FIFO pointers modulo DEPTH; the count width SHALL be clog2(DEPTH)+1.

Reset
REQ-028 SHALL, on wb_rst_i, clear in the next edge: state IDLE, FIFO empty, pointers 0, LEN 0, remaining 0, overflow 0, wbs_ack_o 0, wbs_dat_o 0, irq_o 0, op_valid_o 0, op_last_o 0.
REQ-029 SHALL, if reset occurs mid-burst, abandon the burst with no irq_o; FIFO contents are discarded.

Structure
REQ-030 SHALL place the register offsets, CTRL/STATUS bit positions and FSM state encoding in shared package mac_feeder_pkg.
REQ-031 SHALL implement storage as sub-module mac_op_fifo (sync FIFO; push, pop, flush, full, empty, count).

Verification
REQ-032 SHALL be verified with: LEN=3, push 3 words 0x0201_0005/0x0403_0006/0x0605_0007, start, op_ready_i=1 -> beats a=5,b=0x0201; a=6,b=0x0403; a=7 with op_last_o=1, then irq_o pulses once.
REQ-033 SHALL be verified with: 9 pushes into DEPTH=8 -> STATUS full=1, overflow=1, count=8; then overflow-clear -> overflow=0.
REQ-034 SHALL be verified with: op_ready_i low for 4 cycles mid-burst -> op_valid_o stays high and op_a_o is unchanged; the transfer completes when ready rises.
REQ-035 SHALL be verified with: LEN=4, 2 words queued, start -> after 2 beats op_valid_o=0 and busy=1; push 2 more -> burst completes with irq_o.
REQ-036 SHALL be verified with: flush during RUN -> empty=1, busy=0, no irq_o; and with start while LEN=0 -> state remains IDLE.
REQ-037 SHALL be verified with: wb_rst_i asserted mid-burst -> all outputs at reset values the next cycle, STATUS reads 0x1.
